// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction fetch front end: in-order imem requests, response FIFO, IF/ID register
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        pcsrcE,
    input  logic [31:0] pctargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pcplus4D,
    output logic        validD
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc;
    logic [31:0]   slot_pc    [DEPTH];
    logic [31:0]   slot_instr [DEPTH];
    logic [AW-1:0] head;
    logic [CW-1:0] used;        // allocated slots
    logic [CW-1:0] filled_cnt;  // filled slots; fills are in order so they are contiguous from head
    logic [CW-1:0] drop_cnt;    // outstanding responses belonging to a squashed path

    logic [CW:0]   inflight;
    logic [CW-1:0] unfilled;
    logic [AW-1:0] tail;
    logic [AW-1:0] fill_idx;
    logic          grant;
    logic          accept;
    logic          drop;
    logic          head_ready;
    logic          pop;
    logic [31:0]   head_instr;

    assign inflight  = {1'b0, used} + {1'b0, drop_cnt};
    assign imem_req  = !reset && !stallF && !pcsrcE && (inflight < (CW+1)'(DEPTH));
    assign imem_addr = pc;

    assign unfilled  = used - filled_cnt;
    assign tail      = head + AW'(used);
    assign fill_idx  = head + AW'(filled_cnt);
    assign grant     = imem_req && imem_gnt;
    assign drop      = imem_rvalid && (drop_cnt != '0);
    assign accept    = imem_rvalid && (drop_cnt == '0) && (unfilled != '0);

    // A response landing in an empty-head FIFO bypasses straight into IF/ID.
    assign head_ready = (filled_cnt != '0) || accept;
    assign head_instr = (filled_cnt == '0) ? imem_rdata : slot_instr[head];
    assign pop        = !pcsrcE && !flushD && !stallD && head_ready;

    // PC, FIFO occupancy and squashed-response bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            head       <= '0;
            used       <= '0;
            filled_cnt <= '0;
            drop_cnt   <= '0;
        end else if (pcsrcE) begin
            // Every unfilled slot still has a response coming; the one arriving now is already accounted.
            pc         <= pctargetE;
            head       <= '0;
            used       <= '0;
            filled_cnt <= '0;
            drop_cnt   <= drop_cnt + unfilled - CW'(imem_rvalid);
        end else begin
            if (grant) begin
                pc <= pc + 32'd4;
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            used       <= used + CW'(grant) - CW'(pop);
            filled_cnt <= filled_cnt + CW'(accept) - CW'(pop);
            drop_cnt   <= drop_cnt - CW'(drop);
        end
    end

    // Slot payload: request PC captured at grant, instruction captured at response
    always_ff @(posedge clk) begin
        if (!reset && !pcsrcE) begin
            if (grant) begin
                slot_pc[tail] <= pc;
            end
            if (accept) begin
                slot_instr[fill_idx] <= imem_rdata;
            end
        end
    end

    // IF/ID register: flush beats stall; otherwise load the head or insert a bubble
    always_ff @(posedge clk) begin
        if (reset || flushD) begin
            instrD   <= NOP;
            pcD      <= '0;
            pcplus4D <= '0;
            validD   <= 1'b0;
        end else if (stallD) begin
            instrD   <= instrD;
            pcD      <= pcD;
            pcplus4D <= pcplus4D;
            validD   <= validD;
        end else if (pop) begin
            instrD   <= head_instr;
            pcD      <= slot_pc[head];
            pcplus4D <= slot_pc[head] + 32'd4;
            validD   <= 1'b1;
        end else begin
            instrD   <= NOP;
            pcD      <= '0;
            pcplus4D <= '0;
            validD   <= 1'b0;
        end
    end
endmodule
